// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the MIPS-lite datapath.
// Walks each instruction through fetch/decode/execute/memory/write-back.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_wr,
  output logic [1:0] npc_sel,
  output logic       ir_wr,
  output logic       gpr_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic [1:0] ext_op,
  output logic       dm_wr,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MA     = 4'd2,
    S_MR     = 4'd3,
    S_MWB    = 4'd4,
    S_MW     = 4'd5,
    S_EXE    = 4'd6,
    S_RWB    = 4'd7,
    S_BR     = 4'd8,
    S_JMP    = 4'd9
  } state_e;

  state_e state_q, state_d;

  logic r_type;
  logic is_addu, is_subu, is_jr;
  logic is_ori, is_lui, is_lw, is_sw;
  logic is_beq, is_j, is_jal;
  logic c_mem, c_alu, c_br, c_jmp;

  assign r_type  = (op == 6'b000000);
  assign is_addu = r_type && (funct == 6'b100001);
  assign is_subu = r_type && (funct == 6'b100011);
  assign is_jr   = r_type && (funct == 6'b001000);
  assign is_ori  = (op == 6'b001101);
  assign is_lui  = (op == 6'b001111);
  assign is_lw   = (op == 6'b100011);
  assign is_sw   = (op == 6'b101011);
  assign is_beq  = (op == 6'b000100);
  assign is_j    = (op == 6'b000010);
  assign is_jal  = (op == 6'b000011);

  assign c_mem = is_lw | is_sw;
  assign c_alu = is_addu | is_subu | is_ori | is_lui;
  assign c_br  = is_beq;
  assign c_jmp = is_j | is_jal | is_jr;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          c_mem:   state_d = S_MA;
          c_alu:   state_d = S_EXE;
          c_br:    state_d = S_BR;
          c_jmp:   state_d = S_JMP;
          default: state_d = S_FETCH;
        endcase
      end
      S_MA:     state_d = is_sw ? S_MW : S_MR;
      S_MR:     state_d = S_MWB;
      S_EXE:    state_d = S_RWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  logic       pc_wr_c, ir_wr_c, gpr_wr_c;
  logic       dm_wr_c, ill_c, alu_src_c;
  logic [1:0] npc_c, reg_dst_c, wd_c;
  logic [1:0] alu_op_c, ext_c;

  always_comb begin
    pc_wr_c   = 1'b0;
    ir_wr_c   = 1'b0;
    gpr_wr_c  = 1'b0;
    dm_wr_c   = 1'b0;
    ill_c     = 1'b0;
    alu_src_c = 1'b0;
    npc_c     = 2'b00;
    reg_dst_c = 2'b00;
    wd_c      = 2'b00;
    alu_op_c  = 2'b00;
    ext_c     = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_wr_c = 1'b1;
        pc_wr_c = 1'b1;
      end
      S_DECODE: begin
        ill_c = !(c_mem | c_alu | c_br | c_jmp);
      end
      S_MA, S_MW: begin
        alu_src_c = 1'b1;
        ext_c     = 2'b01;
        dm_wr_c   = (state_q == S_MW);
      end
      S_MWB: begin
        gpr_wr_c = 1'b1;
        wd_c     = 2'b01;
      end
      // RWB keeps the EXE ALU controls so the result stays stable
      S_EXE, S_RWB: begin
        unique case (1'b1)
          is_subu: alu_op_c = 2'b01;
          is_ori: begin
            alu_src_c = 1'b1;
            alu_op_c  = 2'b10;
          end
          is_lui: begin
            alu_src_c = 1'b1;
            ext_c     = 2'b10;
            alu_op_c  = 2'b10;
          end
          default: alu_op_c = 2'b00;
        endcase
        if (state_q == S_RWB) begin
          gpr_wr_c  = 1'b1;
          reg_dst_c = r_type ? 2'b01 : 2'b00;
        end
      end
      S_BR: begin
        alu_op_c = 2'b01;
        npc_c    = 2'b11;
        pc_wr_c  = zero;
      end
      S_JMP: begin
        pc_wr_c = 1'b1;
        npc_c   = is_jr ? 2'b10 : 2'b01;
        if (is_jal) begin
          gpr_wr_c  = 1'b1;
          reg_dst_c = 2'b10;
          wd_c      = 2'b10;
        end
      end
      default: ;
    endcase
  end

  // Reset gates everything: FETCH would otherwise assert ir_wr/pc_wr
  assign pc_wr   = rst & pc_wr_c;
  assign ir_wr   = rst & ir_wr_c;
  assign gpr_wr  = rst & gpr_wr_c;
  assign dm_wr   = rst & dm_wr_c;
  assign illegal = rst & ill_c;
  assign alu_src = rst & alu_src_c;
  assign npc_sel = rst ? npc_c : 2'b00;
  assign reg_dst = rst ? reg_dst_c : 2'b00;
  assign wd_sel  = rst ? wd_c : 2'b00;
  assign alu_op  = rst ? alu_op_c : 2'b00;
  assign ext_op  = rst ? ext_c : 2'b00;
  assign state   = rst ? state_q : 4'd0;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle check of state and all controls.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero;
  logic       pc_wr, ir_wr, gpr_wr, dm_wr, illegal, alu_src;
  logic [1:0] npc_sel, reg_dst, wd_sel, alu_op, ext_op;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .op      (op),
    .funct   (funct),
    .zero    (zero),
    .pc_wr   (pc_wr),
    .npc_sel (npc_sel),
    .ir_wr   (ir_wr),
    .gpr_wr  (gpr_wr),
    .reg_dst (reg_dst),
    .wd_sel  (wd_sel),
    .alu_src (alu_src),
    .alu_op  (alu_op),
    .ext_op  (ext_op),
    .dm_wr   (dm_wr),
    .illegal (illegal),
    .state   (state)
  );

  logic [19:0] obs;
  assign obs = {state, pc_wr, npc_sel, ir_wr, gpr_wr,
                reg_dst, wd_sel, alu_src, alu_op,
                ext_op, dm_wr, illegal};

  function automatic logic [19:0] ev(
    int st, int pcw, int npc, int irw, int gw, int rd,
    int wd, int as, int aop, int ext, int dmw, int ill);
    return {st[3:0], pcw[0], npc[1:0], irw[0], gw[0],
            rd[1:0], wd[1:0], as[0], aop[1:0],
            ext[1:0], dmw[0], ill[0]};
  endfunction

  task automatic chk(string tag, logic [19:0] got,
                     logic [19:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h want %05h", tag, got, exp);
    end
  endtask

  logic [19:0] F, D, Z;

  // Called at a negedge while in FETCH; checks n cycles
  task automatic run_ins(string tag, logic [5:0] o,
                         logic [5:0] f, logic z, int n,
                         logic [19:0] e1, logic [19:0] e2,
                         logic [19:0] e3, logic [19:0] e4);
    logic [19:0] e;
    op = o;
    funct = f;
    zero = z;
    #1 chk({tag, "/c0"}, obs, F);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      case (i)
        1: e = e1;
        2: e = e2;
        3: e = e3;
        default: e = e4;
      endcase
      chk($sformatf("%s/c%0d", tag, i), obs, e);
    end
  endtask

  logic [19:0] ma, mw;

  initial begin
    F  = ev(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    D  = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    Z  = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ma = ev(2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    mw = ev(5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    rst = 1'b0;
    op = 6'd0;
    funct = 6'd0;
    zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", obs, Z);
    rst = 1'b1;

    run_ins("lw", 6'b100011, 6'd0, 1'b0, 5, D, ma,
            ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
            ev(4, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    run_ins("beq1", 6'b000100, 6'd0, 1'b1, 3, D,
            ev(8, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0), Z, Z);
    @(negedge clk);
    run_ins("beq0", 6'b000100, 6'd0, 1'b0, 3, D,
            ev(8, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0), Z, Z);
    @(negedge clk);
    run_ins("jal", 6'b000011, 6'd0, 1'b0, 3, D,
            ev(9, 1, 1, 0, 1, 2, 2, 0, 0, 0, 0, 0), Z, Z);
    @(negedge clk);
    run_ins("addu", 6'd0, 6'b100001, 1'b0, 4, D,
            ev(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
            ev(7, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), Z);
    @(negedge clk);
    run_ins("subu", 6'd0, 6'b100011, 1'b0, 4, D,
            ev(6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0),
            ev(7, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0), Z);
    @(negedge clk);
    run_ins("ori", 6'b001101, 6'd0, 1'b0, 4, D,
            ev(6, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0),
            ev(7, 0, 0, 0, 1, 0, 0, 1, 2, 0, 0, 0), Z);
    @(negedge clk);
    run_ins("lui", 6'b001111, 6'd0, 1'b0, 4, D,
            ev(6, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0),
            ev(7, 0, 0, 0, 1, 0, 0, 1, 2, 2, 0, 0), Z);
    @(negedge clk);
    run_ins("j", 6'b000010, 6'd0, 1'b0, 3, D,
            ev(9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), Z, Z);
    @(negedge clk);
    run_ins("jr", 6'd0, 6'b001000, 1'b0, 3, D,
            ev(9, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), Z, Z);
    @(negedge clk);
    run_ins("illop", 6'b111111, 6'd0, 1'b0, 2,
            ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), Z, Z, Z);
    @(negedge clk);
    run_ins("illfn", 6'd0, 6'b000000, 1'b0, 2,
            ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), Z, Z, Z);
    @(negedge clk);
    run_ins("sw", 6'b101011, 6'd0, 1'b0, 4, D, ma, mw, Z);

    rst = 1'b0;
    #1 chk("rst_mw", obs, Z);
    @(negedge clk);
    chk("rst_hold", obs, Z);
    rst = 1'b1;
    run_ins("post", 6'b001101, 6'd0, 1'b0, 2, D, Z, Z, Z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the MIPS-lite datapath. It walks each instruction through fetch, decode, execute, memory and write-back states, and generates every datapath enable and mux select. This includes `npc_sel` and `pc_wr` for the next-PC unit, so one shared ALU and one memory port serve all phases. It sits between the instruction register fields and the datapath muxes/register enables.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; rising-edge active
- `rst`  in  1  asynchronous, active-low reset
- `op`  in  6  IR[31:26], sampled from the IR register
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag (beq compare)
- `pc_wr`  out  1  PC register load enable; PC loads next-PC output
- `npc_sel`  out  2  to next-PC unit: 00 pc+4, 01 j/jal, 10 jr, 11 beq
- `ir_wr`  out  1  instruction register load enable
- `gpr_wr`  out  1  register file write enable
- `reg_dst`  out  2  write address: 00 rt, 01 rd, 10 r31
- `wd_sel`  out  2  write data: 00 ALU result, 01 memory data register, 10 PC register value
- `alu_src`  out  1  0 = rt data, 1 = extended immediate
- `alu_op`  out  2  00 add, 01 sub, 10 or
- `ext_op`  out  2  00 zero-extend, 01 sign-extend, 10 imm16 << 16
- `dm_wr`  out  1  data memory write enable
- `illegal`  out  1  one-cycle pulse on an undecodable instruction
- `state`  out  4  current state, for debug

## Operation
- States: FETCH(0), DECODE(1), MA(2), MR(3), MWB(4), MW(5), EXE(6), RWB(7), BR(8), JMP(9). Encodings 10–15 are unreachable; if entered, the next state is FETCH.
- Decode: R-type `op`=000000 with `funct` addu 100001, subu 100011, jr 001000. I/J types: ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- FETCH: `ir_wr`=1, `pc_wr`=1, `npc_sel`=00. Next state DECODE.
- DECODE: no writes. Next state by class:
  - lw/sw → MA
  - addu/subu/ori/lui → EXE
  - beq → BR
  - j/jal/jr → JMP
  - anything else → FETCH with `illegal`=1
- MA: `alu_src`=1, `ext_op`=01, `alu_op`=00. Next state MR for lw, MW for sw.
- MR → MWB.
- MWB: `gpr_wr`=1, `reg_dst`=00, `wd_sel`=01. Next state FETCH.
- MW: `dm_wr`=1, MA ALU controls held. Next state FETCH.
- EXE: ALU controls per instruction:
  - addu: `alu_src`=0, `alu_op`=00
  - subu: `alu_src`=0, `alu_op`=01
  - ori: `alu_src`=1, `ext_op`=00, `alu_op`=10
  - lui: `alu_src`=1, `ext_op`=10, `alu_op`=10 (or with `$0`)
  - Next state RWB.
- RWB: `gpr_wr`=1, `wd_sel`=00, `reg_dst`=01 for R-type and 00 for ori/lui. EXE ALU controls are held. Next state FETCH.
- BR: `alu_src`=0, `alu_op`=01, `npc_sel`=11, `pc_wr`=`zero`. Next state FETCH.
  - PC already holds old PC+4 here, so the target is PC+4+(sext(imm16)<<2).
- JMP: `pc_wr`=1.
  - j: `npc_sel`=01
  - jal: `npc_sel`=01, plus `gpr_wr`=1, `reg_dst`=10, `wd_sel`=10 (r31 ← current PC = old PC+4)
  - jr: `npc_sel`=10
  - Next state FETCH.
- Any output not listed for a state is 0.

## Timing
- State register updates on the rising edge of `clk`. Outputs are combinational from state, `op`, `funct` and `zero`.
- Reset: `rst`=0 asynchronously forces state to FETCH. While `rst`=0, `pc_wr`, `ir_wr`, `gpr_wr`, `dm_wr` and `illegal` are forced to 0; all selects read 0 and `state` reads 0.
- After `rst` is released, the first rising edge performs FETCH.
- Cycles per instruction:
  - lw: 5
  - sw, addu, subu, ori, lui: 4
  - beq, j, jal, jr: 3
  - illegal: 2
- `op` and `funct` are only meaningful from DECODE onward. In FETCH they are ignored.
- Reset mid-instruction abandons it. No write enable is asserted on the reset cycle.

## Test plan
- Reset: hold `rst`=0 over 3 edges → `state`=0 and all write enables 0. Release → `ir_wr`=1 and `pc_wr`=1 on the first edge.
- lw (`op`=100011) → states 0,1,2,3,4,0. `gpr_wr`=1 only in state 4, with `wd_sel`=01 and `reg_dst`=00.
- beq (`op`=000100):
  - `zero`=1 → state 8 shows `npc_sel`=11, `pc_wr`=1.
  - `zero`=0 → `pc_wr`=0.
  - Both cases return to FETCH after 3 cycles.
- jal (`op`=000011) → state 9 asserts `pc_wr`, `gpr_wr`, `npc_sel`=01, `reg_dst`=10, `wd_sel`=10 in the same cycle.
- addu (`op`=0, `funct`=100001) → `reg_dst`=01, `alu_op`=00. subu (`funct`=100011) → `alu_op`=01. Both take 4 cycles.
- Illegal `op`=111111 → `illegal` pulses for 1 cycle in DECODE, then FETCH with no writes. Separately, a reset asserted during MW → `dm_wr` drops immediately and `state`=0.
